// File: rtl/fpga_stream_pkg.sv
// fpga_stream_pkg: register map, CTRL/STAT bit positions and defaults for the stream sink
package fpga_stream_pkg;
   localparam int DEPTH_DEFAULT = 32;
   typedef enum logic [1:0] {
      ADDR_CTRL  = 2'd0,
      ADDR_STAT  = 2'd1,
      ADDR_DATA  = 2'd2,
      ADDR_BYTES = 2'd3
   } reg_addr_e;
   localparam int CTRL_EN      = 0;
   localparam int CTRL_FLUSH   = 1;
   localparam int CTRL_CLR     = 2;
   localparam int STAT_EMPTY   = 12;
   localparam int STAT_FULL    = 13;
   localparam int STAT_UDF     = 14;
   localparam int STAT_PKT_LSB = 16;
endpackage

// File: rtl/fpga_byte_fifo.sv
// fpga_byte_fifo: 9-bit {last, byte} FIFO with asynchronous head read and one-cycle flush
import fpga_stream_pkg::*;
module fpga_byte_fifo #(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [8:0]               din,
   output logic [8:0]               head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;
   assign empty   = level == '0;
   assign full    = level == FULL_LVL;
   assign push_ok = push & ~full & ~flush;
   assign pop_ok  = pop & ~empty & ~flush;
   assign head    = mem[rd_ptr];
   always_ff @(posedge clk)
      if (push_ok) mem[wr_ptr] <= din;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop_ok ? rd_ptr + 1'b1 : rd_ptr;
         level  <= level + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      end
endmodule

// File: rtl/fpga_stream_sink.sv
// fpga_stream_sink: AXI-Stream byte sink buffered in a FIFO and drained over an Avalon-MM slave
import fpga_stream_pkg::*;
module fpga_stream_sink #(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  avs_address,
   input  logic        avs_chipselect,
   input  logic        avs_read,
   input  logic        avs_write_n,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   input  logic [7:0]  axis4_s_tdata,
   input  logic        axis4_s_tvalid,
   input  logic        axis4_s_tlast,
   output logic        axis4_s_tready
);
   localparam int AW = $clog2(DEPTH);
   logic          en, flush_pend, udf;
   logic [7:0]    pkt_cnt;
   logic [31:0]   bytes, stat;
   logic [8:0]    head;
   logic [AW:0]   level;
   logic          empty, full, accept, ctrl_wr, clr, data_rd, pop, pkt_inc, pkt_dec;
   logic          unused_wd;
   assign unused_wd = ^avs_writedata[31:3];
   assign axis4_s_tready = en & ~full & ~flush_pend;
   assign accept  = axis4_s_tvalid & axis4_s_tready;
   assign ctrl_wr = avs_chipselect & ~avs_write_n & (avs_address == ADDR_CTRL);
   assign clr     = ctrl_wr & avs_writedata[CTRL_CLR];
   assign data_rd = avs_chipselect & avs_read & (avs_address == ADDR_DATA);
   assign pop     = data_rd & ~empty;
   assign pkt_inc = accept & axis4_s_tlast;
   assign pkt_dec = pop & head[8];
   fpga_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (pop),
      .flush (flush_pend),
      .din   ({axis4_s_tlast, axis4_s_tdata}),
      .head  (head),
      .level (level),
      .empty (empty),
      .full  (full)
   );
   always_comb begin
      stat = '0;
      stat[8:0] = 9'(level);
      stat[STAT_EMPTY] = empty;
      stat[STAT_FULL] = full;
      stat[STAT_UDF] = udf;
      stat[STAT_PKT_LSB +: 8] = pkt_cnt;
   end
   // An empty FIFO reads as 0x200 so stale RAM contents never leak out
   assign avs_readdata = avs_address == ADDR_CTRL ? {31'b0, en} :
                         avs_address == ADDR_STAT ? stat :
                         avs_address == ADDR_DATA ? (empty ? 32'h200 : {23'b0, head}) : bytes;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         en         <= 1'b0;
         flush_pend <= 1'b0;
         udf        <= 1'b0;
         pkt_cnt    <= '0;
         bytes      <= '0;
      end else begin
         if (ctrl_wr) en <= avs_writedata[CTRL_EN];
         flush_pend <= ctrl_wr & avs_writedata[CTRL_FLUSH];
         udf        <= clr ? 1'b0 : udf | (data_rd & empty);
         bytes      <= clr ? {31'b0, accept} : bytes + {31'b0, accept};
         pkt_cnt    <= flush_pend ? 8'd0 :
                       (pkt_inc & ~pkt_dec & pkt_cnt != 8'hFF) ? pkt_cnt + 8'd1 :
                       (pkt_dec & ~pkt_inc & pkt_cnt != 8'h00) ? pkt_cnt - 8'd1 : pkt_cnt;
      end
endmodule

// File: tb/tb_fpga_stream_sink.sv
// tb_fpga_stream_sink: directed and randomized checks of the stream sink against a queue model
module tb_fpga_stream_sink;
   localparam int DEPTH = 32;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  avs_address = 2'd0;
   logic        avs_chipselect = 1'b0;
   logic        avs_read = 1'b0;
   logic        avs_write_n = 1'b1;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic [7:0]  tdata = '0;
   logic        tvalid = 1'b0;
   logic        tlast = 1'b0;
   logic        tready;
   int          n_chk = 0;
   int          n_fail = 0;
   bit [8:0]    q[$];
   bit          m_en, m_fp, m_udf;
   int          m_pkt;
   bit [31:0]   m_bytes;

   always #10 clk = ~clk;

   fpga_stream_sink #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .avs_address    (avs_address),
      .avs_chipselect (avs_chipselect),
      .avs_read       (avs_read),
      .avs_write_n    (avs_write_n),
      .avs_writedata  (avs_writedata),
      .avs_readdata   (avs_readdata),
      .axis4_s_tdata  (tdata),
      .axis4_s_tvalid (tvalid),
      .axis4_s_tlast  (tlast),
      .axis4_s_tready (tready)
   );

   function automatic bit m_ready();
      return m_en && q.size() < DEPTH && !m_fp;
   endfunction

   function automatic logic [31:0] m_read(logic [1:0] a);
      logic [31:0] s;
      s = '0;
      s[8:0] = 9'(q.size());
      s[12] = q.size() == 0;
      s[13] = q.size() == DEPTH;
      s[14] = m_udf;
      s[23:16] = 8'(m_pkt);
      case (a)
         2'd0: return {31'b0, m_en};
         2'd1: return s;
         2'd2: return q.size() == 0 ? 32'h200 : {23'b0, q[0]};
         default: return m_bytes;
      endcase
   endfunction

   task automatic model_reset();
      q.delete();
      m_en = 0; m_fp = 0; m_udf = 0; m_pkt = 0; m_bytes = 0;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      bit acc, rd, wr, e0, last_out;
      bit [8:0] e;
      #1;
      chk("tready", {31'b0, tready}, {31'b0, m_ready()});
      chk("readdata", avs_readdata, m_read(avs_address));
      acc = tvalid && m_ready();
      rd = avs_chipselect && avs_read && avs_address == 2'd2;
      wr = avs_chipselect && !avs_write_n && avs_address == 2'd0;
      e0 = q.size() == 0;
      last_out = 0;
      if (m_fp) begin
         q.delete();
         m_pkt = 0;
      end else begin
         if (rd && !e0) begin
            e = q.pop_front();
            last_out = e[8];
         end
         if (acc) q.push_back({tlast, tdata});
         if (acc && tlast && !last_out) m_pkt = m_pkt == 255 ? 255 : m_pkt + 1;
         else if (last_out && !(acc && tlast) && m_pkt > 0) m_pkt--;
      end
      m_bytes = (wr && avs_writedata[2]) ? 32'(acc) : m_bytes + 32'(acc);
      m_udf = (wr && avs_writedata[2]) ? 1'b0 : (m_udf | (rd && e0));
      m_fp = wr && avs_writedata[1];
      if (wr) m_en = avs_writedata[0];
      @(posedge clk);
      #1;
      avs_chipselect = 0;
      avs_read = 0;
      avs_write_n = 1;
   endtask

   task automatic wr_ctrl(logic [31:0] v);
      avs_chipselect = 1; avs_write_n = 0; avs_address = 2'd0; avs_writedata = v;
      cycle();
   endtask

   task automatic rd_data();
      avs_chipselect = 1; avs_read = 1; avs_address = 2'd2;
      cycle();
   endtask

   task automatic send(logic [7:0] b, logic l);
      tvalid = 1; tdata = b; tlast = l;
      cycle();
      tvalid = 0; tlast = 0;
   endtask

   task automatic peek(logic [1:0] a);
      avs_address = a;
      #1;
   endtask

   initial begin
      int r, rd_pct;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tready", {31'b0, tready}, 32'd0);
      peek(2'd0); chk("rst_ctrl", avs_readdata, 32'd0);
      peek(2'd1); chk("rst_stat", avs_readdata, 32'h1000);
      peek(2'd3); chk("rst_bytes", avs_readdata, 32'd0);
      reset = 0;
      cycle();
      chk("rst_tready_after", {31'b0, tready}, 32'd0);

      // three-beat packet, drained through DATA
      wr_ctrl(32'h1);
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
      peek(2'd1);
      chk("pkt_level", {23'b0, avs_readdata[8:0]}, 32'd3);
      chk("pkt_cnt1", {24'b0, avs_readdata[23:16]}, 32'd1);
      peek(2'd2); chk("data0", avs_readdata, 32'h011); rd_data();
      peek(2'd2); chk("data1", avs_readdata, 32'h022); rd_data();
      peek(2'd2); chk("data2", avs_readdata, 32'h133); rd_data();
      peek(2'd1);
      chk("pkt_empty", {31'b0, avs_readdata[12]}, 32'd1);
      chk("pkt_cnt0", {24'b0, avs_readdata[23:16]}, 32'd0);
      peek(2'd3); chk("pkt_bytes", avs_readdata, 32'd3);

      // fill to full with continuous tvalid
      for (int i = 0; i < 40; i++) begin
         tvalid = 1; tdata = 8'(i); tlast = 0;
         cycle();
      end
      peek(2'd1);
      chk("full_level", {23'b0, avs_readdata[8:0]}, 32'd32);
      chk("full_bit", {31'b0, avs_readdata[13]}, 32'd1);
      chk("full_tready", {31'b0, tready}, 32'd0);
      rd_data();
      chk("full_reopen", {31'b0, tready}, 32'd1);
      tdata = 8'hEE;
      cycle();
      tvalid = 0;
      peek(2'd1); chk("full_again", {23'b0, avs_readdata[8:0]}, 32'd32);

      // underflow and clear
      wr_ctrl(32'h3);
      cycle();
      peek(2'd2); chk("udf_data", avs_readdata, 32'h200);
      rd_data();
      peek(2'd1);
      chk("udf_set", {31'b0, avs_readdata[14]}, 32'd1);
      chk("udf_level", {23'b0, avs_readdata[8:0]}, 32'd0);
      wr_ctrl(32'h5);
      peek(2'd1); chk("udf_clr", {31'b0, avs_readdata[14]}, 32'd0);
      peek(2'd3); chk("clr_bytes", avs_readdata, 32'd0);

      // simultaneous push and pop at level 1
      send(8'hA1, 0);
      tvalid = 1; tdata = 8'hB2; tlast = 0;
      rd_data();
      tvalid = 0;
      peek(2'd1); chk("pp_level", {23'b0, avs_readdata[8:0]}, 32'd1);
      peek(2'd2); chk("pp_data", avs_readdata, 32'h0B2);
      rd_data();

      // flush with ten bytes stored
      wr_ctrl(32'h5);
      for (int i = 0; i < 10; i++) send(8'(8'h40 + i), i % 5 == 4);
      peek(2'd1); chk("fl_level10", {23'b0, avs_readdata[8:0]}, 32'd10);
      wr_ctrl(32'h3);
      chk("fl_tready0", {31'b0, tready}, 32'd0);
      cycle();
      peek(2'd1);
      chk("fl_level0", {23'b0, avs_readdata[8:0]}, 32'd0);
      chk("fl_pkt0", {24'b0, avs_readdata[23:16]}, 32'd0);
      peek(2'd3); chk("fl_bytes", avs_readdata, 32'd10);
      chk("fl_tready1", {31'b0, tready}, 32'd1);

      // randomized traffic against the queue model
      for (int i = 0; i < 1500; i++) begin
         tvalid = $urandom_range(0, 3) != 0;
         tdata = 8'($urandom);
         tlast = $urandom_range(0, 4) == 0;
         rd_pct = i < 750 ? 20 : 60;
         r = $urandom_range(0, 99);
         if (r < rd_pct) begin
            avs_chipselect = 1; avs_read = 1; avs_address = 2'd2;
         end else if (r < rd_pct + 2) begin
            avs_chipselect = 1; avs_write_n = 0; avs_address = 2'd0;
            avs_writedata = $urandom;
            if ($urandom_range(0, 3) != 0) avs_writedata[0] = 1;
         end else if (r < rd_pct + 4) begin
            avs_chipselect = 1; avs_write_n = 0;
            avs_address = 2'($urandom_range(1, 3));
            avs_writedata = $urandom;
         end else if (r < rd_pct + 6) begin
            avs_read = 1; avs_address = 2'd2;
         end else begin
            avs_address = 2'($urandom_range(0, 3));
         end
         cycle();
      end
      tvalid = 0;

      // reset in the middle of a packet
      wr_ctrl(32'h5);
      wr_ctrl(32'h3);
      cycle();
      for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 0);
      tvalid = 1;
      reset = 1;
      #1;
      model_reset();
      chk("mid_tready", {31'b0, tready}, 32'd0);
      peek(2'd0); chk("mid_ctrl", avs_readdata, 32'd0);
      peek(2'd1); chk("mid_stat", avs_readdata, 32'h1000);
      peek(2'd2); chk("mid_data", avs_readdata, 32'h200);
      peek(2'd3); chk("mid_bytes", avs_readdata, 32'd0);
      @(posedge clk);
      #1;
      reset = 0;
      cycle();
      cycle();
      tvalid = 0;
      wr_ctrl(32'h1);
      send(8'h71, 0); send(8'h72, 0); send(8'h73, 1);
      peek(2'd3); chk("post_bytes", avs_readdata, 32'd3);
      peek(2'd1);
      chk("post_pkt", {24'b0, avs_readdata[23:16]}, 32'd1);
      chk("post_level", {23'b0, avs_readdata[8:0]}, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
